// File: rtl/lab_1_selftest_pkg.sv
// Shared types and sizes for the lab_1 built-in self-test sequencer.
package lab_1_selftest_pkg;

  localparam int VEC_W   = 3;
  localparam int NUM_VEC = 8;
  localparam int CNT_W   = 4;
  localparam int ERR_W   = 4;

  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/lab_1_selftest_ctrl.sv
// Self-test sequencer: sweeps {a,b,c} through all 8 vectors, checks {x,y}
// against golden truth tables and reports pass, error count and first failure.
module lab_1_selftest_ctrl
  import lab_1_selftest_pkg::*;
#(
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0]   EXP_X         = 8'b11101000,
  parameter logic [NUM_VEC-1:0]   EXP_Y         = 8'b10010110
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_c,
  input  logic             dut_x,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [VEC_W-1:0]   r_vec;
  logic [CNT_W-1:0]   r_cnt;
  logic [ERR_W-1:0]   r_err;
  logic [VEC_W-1:0]   r_fail_vec;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;

  logic               w_accept;
  logic               w_sample;
  logic               w_mismatch;
  logic               w_err_inc;
  logic [ERR_W-1:0]   w_err_next;

  // NOTE: reset is sampled on the clock edge (synchronous); all state uses <=
  // so every register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt == CNT_LAST) w_state_next = SAMPLE;
      end
      SAMPLE: begin
        w_sample     = 1'b1;
        w_state_next = (r_vec == VEC_LAST) ? DONE : SETTLE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The DUT response is compared directly; it shares this clock domain.
  assign w_mismatch = (dut_x != EXP_X[r_vec]) || (dut_y != EXP_Y[r_vec]);
  assign w_err_inc  = w_sample && w_mismatch;
  assign w_err_next = r_err + {{(ERR_W-1){1'b0}}, w_err_inc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec      <= '0;
      r_cnt      <= '0;
      r_err      <= '0;
      r_fail_vec <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_vec      <= '0;
        r_cnt      <= '0;
        r_err      <= '0;
        r_fail_vec <= '0;
        r_pass     <= 1'b0;
        r_busy     <= 1'b1;
      end
      if (r_state == SETTLE) r_cnt <= r_cnt + 1'b1;
      if (w_sample) begin
        r_err <= w_err_next;
        if (w_err_inc && (r_err == '0)) r_fail_vec <= r_vec;
        // done and pass are registered on entry to DONE so they are valid there.
        if (r_vec == VEC_LAST) begin
          r_done <= 1'b1;
          r_pass <= (w_err_next == '0);
        end else begin
          r_vec <= r_vec + 1'b1;
          r_cnt <= '0;
        end
      end
      if (r_state == DONE) r_busy <= 1'b0;
    end
  end

  assign {dut_a, dut_b, dut_c} = r_vec;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err;
  assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_lab_1_selftest_ctrl.sv
// Scoreboard bench: two sequencers (settle 2 and settle 1) each driving a
// full-adder model of lab_1, with fault injection on the first one.
`timescale 1ns/1ps
module tb_lab_1_selftest_ctrl;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic [2:0] fv;
    int         edge_no;
  } exp_t;

  typedef enum {F_NONE, F_Y0, F_X1, F_XINV} fault_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  fault_t fault = F_NONE;

  logic a0, b0, c0, x0, y0, busy0, done0, pass0;
  logic [3:0] err0;
  logic [2:0] fv0;
  logic a1, b1, c1, x1, y1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [2:0] fv1;
  logic maj0, sum0;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t mon0_e, mon1_e;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // lab_1 models: full adder, x = carry, y = sum
  assign maj0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
  assign sum0 = a0 ^ b0 ^ c0;
  assign x0   = (fault == F_X1) ? 1'b1 : (fault == F_XINV) ? ~maj0 : maj0;
  assign y0   = (fault == F_Y0) ? 1'b0 : sum0;
  assign x1   = (a1 & b1) | (a1 & c1) | (b1 & c1);
  assign y1   = a1 ^ b1 ^ c1;

  lab_1_selftest_ctrl #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_x(x0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
  );

  lab_1_selftest_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .dut_a(a1), .dut_b(b1), .dut_c(c1), .dut_x(x1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitors: pop the expected result whenever a done pulse appears.
  always @(negedge clk) begin
    if (rst_n && done0) begin
      if (sb0.size() == 0) check("dut0_unexpected_done", 32'(sb0.size()), 1);
      else begin
        mon0_e = sb0.pop_front();
        check("dut0_done_edge", edge_cnt, mon0_e.edge_no);
        check("dut0_pass", pass0, mon0_e.pass);
        check("dut0_err_count", err0, mon0_e.err);
        if (mon0_e.err != 0) check("dut0_fail_vec", fv0, mon0_e.fv);
        check("dut0_busy_in_done", busy0, 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (sb1.size() == 0) check("dut1_unexpected_done", 32'(sb1.size()), 1);
      else begin
        mon1_e = sb1.pop_front();
        check("dut1_done_edge", edge_cnt, mon1_e.edge_no);
        check("dut1_pass", pass1, mon1_e.pass);
        check("dut1_err_count", err1, mon1_e.err);
        if (mon1_e.err != 0) check("dut1_fail_vec", fv1, mon1_e.fv);
      end
    end
  end

  task automatic check_all_zero();
    check("rst_abc0", {a0, b0, c0}, 0);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_pass0", pass0, 0);
    check("rst_err0", err0, 0);
    check("rst_fv0", fv0, 0);
    check("rst_abc1", {a1, b1, c1}, 0);
    check("rst_busy1", busy1, 0);
    check("rst_pass1", pass1, 0);
    check("rst_err1", err1, 0);
  endtask

  // One full sweep on dut0 (s=2) or dut1 (s=1); extra pulses start during busy/DONE.
  task automatic sweep(input int s, input logic e_pass, input logic [3:0] e_err,
                       input logic [2:0] e_fv, input bit extra);
    int a_edge, per, last_rel;
    bit busy_ok;
    logic [2:0] vec_exp, vec_act;
    logic busy_act;
    per      = s + 1;
    last_rel = 8 * per;
    @(negedge clk);
    a_edge = edge_cnt + 1;
    if (s == 2) begin
      start0 = 1'b1;
      sb0.push_back('{e_pass, e_err, e_fv, a_edge + last_rel});
    end else begin
      start1 = 1'b1;
      sb1.push_back('{e_pass, e_err, e_fv, a_edge + last_rel});
    end
    busy_ok = 1'b1;
    for (int rel = 0; rel <= last_rel + 2; rel++) begin
      @(negedge clk);
      start0   = extra && (rel == 4 || rel == 23 || rel == 24);
      start1   = 1'b0;
      vec_act  = (s == 2) ? {a0, b0, c0} : {a1, b1, c1};
      busy_act = (s == 2) ? busy0 : busy1;
      if (rel == 0) begin
        check("pass_cleared_on_accept", (s == 2) ? pass0 : pass1, 0);
        check("err_cleared_on_accept", (s == 2) ? err0 : err1, 0);
      end
      vec_exp = (rel < last_rel) ? 3'(rel / per) : 3'd7;
      if (rel <= last_rel) begin
        check("vec_trace", vec_act, vec_exp);
        busy_ok &= busy_act;
      end else begin
        check("busy_after_done", busy_act, 0);
      end
    end
    check("busy_continuous", busy_ok, 1);
    check("done_seen", (s == 2) ? sb0.size() : sb1.size(), 0);
  endtask

  initial begin
    exp_t dropped;
    int a_edge;

    repeat (3) @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;

    fault = F_NONE; sweep(2, 1'b1, 4'd0, 3'd0, 1'b0);
    fault = F_Y0;   sweep(2, 1'b0, 4'd4, 3'd1, 1'b0);
    fault = F_X1;   sweep(2, 1'b0, 4'd4, 3'd0, 1'b0);
    fault = F_XINV; sweep(2, 1'b0, 4'd8, 3'd0, 1'b0);
    fault = F_NONE; sweep(2, 1'b1, 4'd0, 3'd0, 1'b1);
    sweep(1, 1'b1, 4'd0, 3'd0, 1'b0);

    // Abort a faulty sweep during vector 3 with reset.
    fault = F_Y0;
    @(negedge clk);
    start0 = 1'b1;
    sb0.push_back('{1'b0, 4'd0, 3'd0, edge_cnt + 25});
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    check("vec_before_reset", {a0, b0, c0}, 3);
    check("err_before_reset", err0, 2);
    check("fv_before_reset", fv0, 1);
    rst_n   = 1'b0;
    dropped = sb0.pop_back();
    @(negedge clk);
    check_all_zero();
    rst_n = 1'b1;
    fault = F_NONE;
    repeat (30) @(negedge clk);
    check("no_done_after_abort", sb0.size(), 0);
    sweep(2, 1'b1, 4'd0, 3'd0, 1'b0);

    // start held high on dut1: back-to-back sweeps, re-accepted two edges after done.
    @(negedge clk);
    a_edge = edge_cnt + 1;
    start1 = 1'b1;
    sb1.push_back('{1'b1, 4'd0, 3'd0, a_edge + 16});
    sb1.push_back('{1'b1, 4'd0, 3'd0, a_edge + 34});
    for (int rel = 0; rel <= 38; rel++) begin
      @(negedge clk);
      if (rel == 17) check("hold_busy_gap", busy1, 0);
      if (rel == 18) begin
        check("hold_reaccept_busy", busy1, 1);
        start1 = 1'b0;
      end
    end
    check("hold_two_dones", sb1.size(), 0);
    check("hold_idle_end", busy1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
